dmem_march_bist: RTL and testbench
==================================

Name: dmem_march_bist

Overview:
- Synthesizable bus initiator that drives the data-memory write/read port (memwrite, dataadr, writedata, readdata) from the master side, in place of the processor.
- Runs a three-phase march test over a word-aligned window of dmem and reports pass/fail, the first failing address and data, and an error count.
- Used for self-test of dmem before the core is released from reset, and as a stimulus source for memory-side debug.

Parameters:
- DEPTH, 64, number of 32-bit words tested (1..65535)
- BASE_ADDR, 32'h0000_0000, byte address of the first word; must be word-aligned
- SEED, 32'h0000_0000, pattern seed; pattern(i) = SEED ^ {i[15:0], i[15:0]}, where i is the word index from 0

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  level-sampled; accepted only in IDLE
- memwrite  out  1  dmem write enable; write commits at the rising edge
- dataadr  out  32  byte address = BASE_ADDR + 4*i
- writedata  out  32  write data
- readdata  in  32  dmem combinational read data for dataadr
- busy  out  1  high from the first test cycle to the last test cycle
- done  out  1  one-cycle pulse after the last test cycle
- pass  out  1  valid once done has pulsed; held until next start accepted
- err_count  out  8  total mismatches, saturating at 255
- fail_addr  out  32  byte address of the first mismatch
- fail_data  out  32  readdata observed at the first mismatch

Behaviour:
- Reset (reset=0 at rising edge):
  - state=IDLE
  - memwrite=0, dataadr=BASE_ADDR, writedata=0
  - busy=0, done=0, pass=0, err_count=0, fail_addr=0, fail_data=0
  - Reset mid-test aborts immediately; no further writes occur after that edge.
- States: IDLE, W_UP, RW_UP, R_DN, DONE.
- IDLE:
  - start=1 at an edge -> W_UP with i=0.
  - Clears err_count/fail_*/pass at that same edge.
  - busy=1 from the next cycle.
- W_UP: one word per cycle, i = 0..DEPTH-1, memwrite=1, writedata=pattern(i). After i=DEPTH-1 -> RW_UP with i=0.
- RW_UP: one word per cycle, ascending.
  - memwrite=1, writedata=~pattern(i).
  - readdata is compared to pattern(i) in the same cycle; the old value is visible because the read is combinational before the write edge.
  - After i=DEPTH-1 -> R_DN with i=DEPTH-1.
- R_DN: one word per cycle, descending, memwrite=0, compare readdata to ~pattern(i). After i=0 -> DONE.
- DONE: one cycle.
  - busy=0, done=1, pass=(err_count==0).
  - Next state IDLE. If start is still high, the next run begins the following edge.
- Test length: exactly 3*DEPTH busy cycles; memwrite is high for exactly 2*DEPTH of them.
- Mismatch handling:
  - err_count += 1, saturating at 255.
  - If it is the first mismatch, capture fail_addr=dataadr and fail_data=readdata.
  - The test continues; it never aborts on error.
- start while busy or in DONE: ignored.
- Outputs are registered; dataadr/writedata/memwrite change only at rising edges.
- dataadr wraps modulo 2^32; no bounds checking against dmem size.

Test Plan:
1. Ideal 64-word dmem, defaults, start pulsed one cycle -> busy for 192 cycles; memwrite high for cycles 1-128 only; done pulse at cycle 193; pass=1, err_count=0; afterwards dmem word i = ~(i<<16 | i), e.g. word 5 = 32'hFFFA_FFFA.
2. Word 5 bit 3 stuck at 0 -> R_DN mismatch at word 5; fail_addr=32'h14, fail_data=32'hFFFA_FFF2, err_count=1, pass=0.
3. Memory ignores writes (all zero) -> RW_UP mismatches i=1..63, R_DN mismatches all 64; err_count=127, fail_addr=32'h4, fail_data=0, pass=0.
4. reset driven 0 at busy cycle 50 -> next edge memwrite=0, busy=0, err_count=0, pass=0; a subsequent start completes with pass=1.
5. BASE_ADDR=32'h40, DEPTH=4:
   - dataadr sequence 40,44,48,4C (W_UP), 40,44,48,4C (RW_UP), 4C,48,44,40 (R_DN); busy 12 cycles.
   - start toggled during busy changes nothing.
6. Defaults, start held high continuously -> back-to-back runs: done pulse, one IDLE cycle, busy again; pass re-evaluated per run.

Source files
------------

// File: rtl/dmem_march_bist.sv
// March-test BIST initiator for the data-memory port: write pattern ascending,
// read-check/write-inverse ascending, read-check inverse descending.
module dmem_march_bist #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] SEED      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        memwrite,
  output logic [31:0] dataadr,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data
);

  typedef enum logic [2:0] {IDLE, W_UP, RW_UP, R_DN, DONE} state_t;

  localparam logic [15:0] LAST = 16'(DEPTH - 1);

  state_t      state, state_n;
  logic [15:0] idx, idx_n;
  logic        mismatch;
  logic        accept;
  logic [7:0]  err_n;

  function automatic logic [31:0] pattern(input logic [15:0] i);
    return SEED ^ {i, i};
  endfunction

  function automatic logic [31:0] addr_of(input logic [15:0] i);
    return BASE_ADDR + {14'd0, i, 2'b00};
  endfunction

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: if (start) begin
        state_n = W_UP;
        idx_n   = '0;
      end
      W_UP: if (idx == LAST) begin
        state_n = RW_UP;
        idx_n   = '0;
      end else begin
        idx_n = idx + 16'd1;
      end
      RW_UP: if (idx == LAST) begin
        state_n = R_DN;
        idx_n   = LAST;
      end else begin
        idx_n = idx + 16'd1;
      end
      R_DN: if (idx == '0) begin
        state_n = DONE;
      end else begin
        idx_n = idx - 16'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // readdata is combinational, so in RW_UP it still shows the old word before the write edge
  always_comb begin
    mismatch = 1'b0;
    if (state == RW_UP)
      mismatch = (readdata != pattern(idx));
    else if (state == R_DN)
      mismatch = (readdata != ~pattern(idx));
    err_n  = err_count;
    if (mismatch && err_count != 8'hFF)
      err_n = err_count + 8'd1;
    accept = (state == IDLE) && start;
  end

  // Outputs are registered from the next state so they describe the cycle being entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      memwrite  <= 1'b0;
      dataadr   <= BASE_ADDR;
      writedata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      memwrite <= (state_n == W_UP) || (state_n == RW_UP);
      busy     <= state_n inside {W_UP, RW_UP, R_DN};
      done     <= (state_n == DONE);
      if (state_n inside {W_UP, RW_UP, R_DN})
        dataadr <= addr_of(idx_n);
      if (state_n == W_UP)
        writedata <= pattern(idx_n);
      else if (state_n == RW_UP)
        writedata <= ~pattern(idx_n);
      if (accept) begin
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
        pass      <= 1'b0;
      end else begin
        err_count <= err_n;
        if (mismatch && err_count == '0) begin
          fail_addr <= dataadr;
          fail_data <= readdata;
        end
        if (state_n == DONE)
          pass <= (err_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_dmem_march_bist.sv
// Bench for dmem_march_bist: two instances (64 words at 0, 4 words at 0x40)
// against behavioural memories and a cycle-count based reference model.
module tb_dmem_march_bist;

  localparam int          D0 = 64;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] S0 = 32'h0000_0000;
  localparam int          D1 = 4;
  localparam logic [31:0] B1 = 32'h0000_0040;
  localparam logic [31:0] S1 = 32'hA5A5_0F0F;

  logic clk = 1'b0, reset = 1'b0, st0 = 1'b0, st1 = 1'b0;
  always #5 clk = ~clk;

  logic        mw0, mw1, busy0, busy1, done0, done1, pass0, pass1;
  logic [31:0] adr0, adr1, wd0, wd1, rd0, rd1, fa0, fa1, fd0, fd1;
  logic [7:0]  ec0, ec1;

  dmem_march_bist #(.DEPTH(D0), .BASE_ADDR(B0), .SEED(S0)) u0 (
    .clk(clk), .reset(reset), .start(st0), .memwrite(mw0), .dataadr(adr0),
    .writedata(wd0), .readdata(rd0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(ec0), .fail_addr(fa0), .fail_data(fd0));

  dmem_march_bist #(.DEPTH(D1), .BASE_ADDR(B1), .SEED(S1)) u1 (
    .clk(clk), .reset(reset), .start(st1), .memwrite(mw1), .dataadr(adr1),
    .writedata(wd1), .readdata(rd1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(ec1), .fail_addr(fa1), .fail_data(fd1));

  // Memories: fmode 0 ideal, 1 word 5 bit 3 stuck at 0, 2 writes ignored
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [4];
  int          fmode = 0;
  logic        clr0  = 1'b0;
  logic [5:0]  ix0;
  assign ix0 = adr0[7:2];

  always @(posedge clk) begin
    if (clr0) begin
      for (int j = 0; j < 64; j++) mem0[j] <= '0;
      for (int j = 0; j < 4; j++)  mem1[j] <= '0;
    end else begin
      if (mw0 && fmode != 2) mem0[ix0] <= wd0;
      if (mw1) mem1[adr1[3:2]] <= wd1;
    end
  end

  always_comb rd0 = (fmode == 1 && ix0 == 6'd5) ? (mem0[ix0] & ~32'h8) : mem0[ix0];
  assign rd1 = mem1[adr1[3:2]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: mk = cycle number within a run (0 idle, 1..3D busy, 3D+1 done)
  int          mk     [2];
  int unsigned merr   [2];
  logic [31:0] mfa    [2];
  logic [31:0] mfd    [2];
  logic        mpass  [2];
  bit          mvalid [2];

  function automatic int dep(input int n);
    return (n == 0) ? D0 : D1;
  endfunction

  function automatic logic [31:0] bas(input int n);
    return (n == 0) ? B0 : B1;
  endfunction

  function automatic logic [31:0] pat(input int n, input int i);
    logic [15:0] h;
    h = 16'(i);
    return ((n == 0) ? S0 : S1) ^ {h, h};
  endfunction

  function automatic int widx(input int n, input int k);
    int d;
    d = dep(n);
    if (k <= d) return k - 1;
    if (k <= 2 * d) return k - d - 1;
    return 3 * d - k;
  endfunction

  task automatic model_step(input int n, input logic st, input logic [31:0] rd);
    int d, i;
    logic [31:0] ex;
    d = dep(n);
    if (!reset) begin
      mk[n] = 0; merr[n] = 0; mfa[n] = '0; mfd[n] = '0; mpass[n] = 1'b0; mvalid[n] = 1'b1;
      return;
    end
    if (mk[n] > d && mk[n] <= 3 * d) begin
      i  = widx(n, mk[n]);
      ex = (mk[n] <= 2 * d) ? pat(n, i) : ~pat(n, i);
      if (rd !== ex) begin
        if (merr[n] == 0) begin
          mfa[n] = bas(n) + 32'(4 * i);
          mfd[n] = rd;
        end
        if (merr[n] < 255) merr[n]++;
      end
    end
    if (mk[n] == 0) begin
      if (st === 1'b1) begin
        mk[n] = 1; merr[n] = 0; mfa[n] = '0; mfd[n] = '0; mpass[n] = 1'b0;
      end
    end else if (mk[n] == 3 * d) begin
      mk[n] = 3 * d + 1;
      mpass[n] = (merr[n] == 0);
    end else if (mk[n] == 3 * d + 1) begin
      mk[n] = 0;
    end else begin
      mk[n]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, st0, rd0);
    model_step(1, st1, rd1);
  end

  task automatic cmp(input int n, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                     input logic b, input logic dn, input logic p, input logic [7:0] ec,
                     input logic [31:0] fa, input logic [31:0] fd);
    int d, k, i;
    bit bz;
    if (!mvalid[n]) return;
    d  = dep(n);
    k  = mk[n];
    bz = (k >= 1 && k <= 3 * d);
    chk($sformatf("u%0d.busy k=%0d", n, k), 32'(b), 32'(bz));
    chk($sformatf("u%0d.done k=%0d", n, k), 32'(dn), 32'(k == 3 * d + 1));
    chk($sformatf("u%0d.memwrite k=%0d", n, k), 32'(mw), 32'(k >= 1 && k <= 2 * d));
    if (bz) begin
      i = widx(n, k);
      chk($sformatf("u%0d.dataadr k=%0d", n, k), a, bas(n) + 32'(4 * i));
      if (k <= 2 * d)
        chk($sformatf("u%0d.writedata k=%0d", n, k), wd, (k <= d) ? pat(n, i) : ~pat(n, i));
    end
    chk($sformatf("u%0d.err_count k=%0d", n, k), 32'(ec), merr[n]);
    chk($sformatf("u%0d.fail_addr k=%0d", n, k), fa, mfa[n]);
    chk($sformatf("u%0d.fail_data k=%0d", n, k), fd, mfd[n]);
    chk($sformatf("u%0d.pass k=%0d", n, k), 32'(p), 32'(mpass[n]));
  endtask

  always @(negedge clk) begin
    cmp(0, mw0, adr0, wd0, busy0, done0, pass0, ec0, fa0, fd0);
    cmp(1, mw1, adr1, wd1, busy1, done1, pass1, ec1, fa1, fd1);
  end

  // Pulses start for one edge; returns at the negedge of busy cycle 1
  task automatic start0();
    @(negedge clk); st0 = 1'b1;
    @(negedge clk); st0 = 1'b0;
  endtask

  task automatic run0(output int nb, output int nw, output int dc);
    nb = 0; nw = 0; dc = 0;
    start0();
    for (int c = 1; c <= 400; c++) begin
      if (busy0) nb++;
      if (mw0) nw++;
      if (done0) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done0(output int dc);
    dc = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (done0) begin
        dc = c;
        break;
      end
    end
  endtask

  logic [31:0] exp5 [12] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h40, 32'h44,
                             32'h48, 32'h4C, 32'h4C, 32'h48, 32'h44, 32'h40};

  initial begin
    int nb, nw, dc;
    clr0 = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    clr0 = 1'b0;
    chk("rst.memwrite", 32'(mw0), 32'd0);
    chk("rst.dataadr0", adr0, 32'h0);
    chk("rst.dataadr1", adr1, 32'h40);
    chk("rst.writedata", wd0, 32'h0);
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.done", 32'(done0), 32'd0);
    chk("rst.pass", 32'(pass0), 32'd0);
    chk("rst.err_count", 32'(ec0), 32'd0);
    chk("rst.fail_addr", fa0, 32'h0);
    chk("rst.fail_data", fd0, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Ideal memory, default parameters
    fmode = 0;
    run0(nb, nw, dc);
    chk("t1.busy_cycles", 32'(nb), 32'd192);
    chk("t1.write_cycles", 32'(nw), 32'd128);
    chk("t1.done_cycle", 32'(dc), 32'd193);
    chk("t1.pass", 32'(pass0), 32'd1);
    chk("t1.err_count", 32'(ec0), 32'd0);
    chk("t1.mem5", mem0[5], 32'hFFFA_FFFA);
    chk("t1.mem63", mem0[63], 32'hFFC0_FFC0);
    repeat (2) @(negedge clk);

    // Word 5 bit 3 stuck at 0
    fmode = 1;
    run0(nb, nw, dc);
    chk("t2.err_count", 32'(ec0), 32'd1);
    chk("t2.fail_addr", fa0, 32'h14);
    chk("t2.fail_data", fd0, 32'hFFFA_FFF2);
    chk("t2.pass", 32'(pass0), 32'd0);
    repeat (2) @(negedge clk);

    // Writes ignored, memory all zero
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    fmode = 2;
    run0(nb, nw, dc);
    chk("t3.busy_cycles", 32'(nb), 32'd192);
    chk("t3.err_count", 32'(ec0), 32'd127);
    chk("t3.fail_addr", fa0, 32'h4);
    chk("t3.fail_data", fd0, 32'h0);
    chk("t3.pass", 32'(pass0), 32'd0);
    repeat (2) @(negedge clk);

    // Reset at busy cycle 50 aborts the run
    fmode = 0;
    start0();
    repeat (49) @(negedge clk);
    chk("t4.busy_before", 32'(busy0), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t4.memwrite", 32'(mw0), 32'd0);
    chk("t4.busy", 32'(busy0), 32'd0);
    chk("t4.err_count", 32'(ec0), 32'd0);
    chk("t4.pass", 32'(pass0), 32'd0);
    chk("t4.dataadr", adr0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    run0(nb, nw, dc);
    chk("t4.done_cycle", 32'(dc), 32'd193);
    chk("t4.pass_after", 32'(pass0), 32'd1);
    repeat (2) @(negedge clk);

    // Small window at 0x40, start toggled while busy
    @(negedge clk); st1 = 1'b1;
    @(negedge clk); st1 = 1'b0;
    nb = 0;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("t5.dataadr%0d", c), adr1, exp5[c-1]);
      if (busy1) nb++;
      st1 = (c >= 2 && c <= 10) ? c[0] : 1'b0;
      @(negedge clk);
    end
    chk("t5.busy_cycles", 32'(nb), 32'd12);
    chk("t5.done", 32'(done1), 32'd1);
    chk("t5.pass", 32'(pass1), 32'd1);
    @(negedge clk);
    chk("t5.idle_after", 32'(busy1), 32'd0);

    // start held high: back-to-back runs, pass re-evaluated
    fmode = 1;
    @(negedge clk); st0 = 1'b1;
    wait_done0(dc);
    chk("t6.done1_cycle", 32'(dc), 32'd193);
    chk("t6.pass1", 32'(pass0), 32'd0);
    chk("t6.err1", 32'(ec0), 32'd1);
    fmode = 0;
    @(negedge clk);
    chk("t6.gap_busy", 32'(busy0), 32'd0);
    chk("t6.gap_done", 32'(done0), 32'd0);
    @(negedge clk);
    chk("t6.rerun_busy", 32'(busy0), 32'd1);
    wait_done0(dc);
    st0 = 1'b0;
    chk("t6.done2_cycle", 32'(dc), 32'd192);
    chk("t6.pass2", 32'(pass0), 32'd1);
    chk("t6.err2", 32'(ec0), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6.stopped", 32'(busy0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
